// File: rtl/scan_resp_pkg.sv
// Shared types and defaults for the scan response monitor.
// Optional bit-compare feature is enabled with SCAN_RESP_BITCMP_EN.
package scan_resp_pkg;

  localparam int unsigned NUM_W_DEF  = 20;
  localparam int unsigned MISR_W_DEF = 32;
  localparam int unsigned PAT_W_DEF  = 16;
  localparam int unsigned MIS_W      = 16;

  localparam logic [31:0] MISR_POLY_DEF = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED_DEF = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPT,
    ST_CMP,
    ST_DONE,
    ST_ABORT
  } state_t;

endpackage

// File: rtl/scan_misr.sv
// Multiple-input signature register: one shift/feedback step per enabled cycle.
// Serial input is folded into bit 0; load restores the seed.
module scan_misr
  import scan_resp_pkg::*;
#(
  parameter int unsigned     W    = MISR_W_DEF,
  parameter logic [W-1:0]    POLY = W'(MISR_POLY_DEF),
  parameter logic [W-1:0]    SEED = W'(MISR_SEED_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_step;

  always_comb begin
    sig_step = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ W'(din);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_step;
    end
  end

endmodule

// File: rtl/scan_resp_monitor.sv
// Scan response monitor: compresses unloaded patterns, checks window lengths,
// and reports pass/fail at end of test. Optional macro: SCAN_RESP_BITCMP_EN.
module scan_resp_monitor
  import scan_resp_pkg::*;
#(
  parameter int unsigned       NUM_W     = NUM_W_DEF,
  parameter int unsigned       MISR_W    = MISR_W_DEF,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(MISR_POLY_DEF),
  parameter logic [MISR_W-1:0] MISR_SEED = MISR_W'(MISR_SEED_DEF),
  parameter int unsigned       PAT_W     = PAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ADPLL_LOCK,
  input  logic [NUM_W-1:0]  ScanNum,
  input  logic              test_se,
  input  logic              scan_done,
  input  logic              so_vld,
  input  logic              scan_so,
  input  logic [MISR_W-1:0] exp_sig,
`ifdef SCAN_RESP_BITCMP_EN
  input  logic              exp_bit,
  output logic [MIS_W-1:0]  mis_cnt,
`endif
  output logic [MISR_W-1:0] resp_sig,
  output logic [PAT_W-1:0]  pat_cnt,
  output logic              resp_done,
  output logic              resp_pass,
  output logic              resp_err
);

  state_t state, state_nx;

  logic se_cur, se_prev, done_cur, done_prev;
  logic se_rise, se_fall, done_rise;

  logic start, new_win, accept, close_win, do_cmp, do_abort;
  logic compress;
  logic mis_ok;

  logic [NUM_W-1:0] bit_cnt, bit_cnt_inc, bit_cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      se_cur    <= 1'b0;
      se_prev   <= 1'b0;
      done_cur  <= 1'b0;
      done_prev <= 1'b0;
    end else begin
      se_cur    <= test_se;
      se_prev   <= se_cur;
      done_cur  <= scan_done;
      done_prev <= done_cur;
    end
  end

  assign se_rise   = se_cur & ~se_prev;
  assign se_fall   = ~se_cur & se_prev;
  assign done_rise = done_cur & ~done_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    new_win   = 1'b0;
    accept    = 1'b0;
    close_win = 1'b0;
    do_cmp    = 1'b0;
    do_abort  = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (se_rise) begin
          state_nx = ST_SHIFT;
          start    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!ADPLL_LOCK) begin
          state_nx = ST_ABORT;
          do_abort = 1'b1;
        end else begin
          accept = so_vld;
          // A window closing together with scan_done is still counted and checked.
          if (se_fall) begin
            close_win = 1'b1;
            state_nx  = ST_CAPT;
          end
          if (done_rise) state_nx = ST_CMP;
        end
      end
      ST_CAPT: begin
        if (!ADPLL_LOCK) begin
          state_nx = ST_ABORT;
          do_abort = 1'b1;
        end else if (done_rise) begin
          state_nx = ST_CMP;
        end else if (se_rise) begin
          state_nx = ST_SHIFT;
          new_win  = 1'b1;
        end
      end
      ST_CMP: begin
        if (!ADPLL_LOCK) begin
          state_nx = ST_ABORT;
          do_abort = 1'b1;
        end else begin
          state_nx = ST_DONE;
          do_cmp   = 1'b1;
        end
      end
      ST_ABORT: begin
        if (ADPLL_LOCK && !se_cur && !done_cur) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign compress    = accept && (pat_cnt != '0);
  assign bit_cnt_inc = (&bit_cnt) ? bit_cnt : bit_cnt + NUM_W'(1);
  // Length check sees the bit accepted in the closing cycle.
  assign bit_cnt_nx  = accept ? bit_cnt_inc : bit_cnt;

  scan_misr #(
    .W    (MISR_W),
    .POLY (MISR_POLY),
    .SEED (MISR_SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start),
    .en    (compress),
    .din   (scan_so),
    .sig   (resp_sig)
  );

`ifdef SCAN_RESP_BITCMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt <= '0;
    end else if (start) begin
      mis_cnt <= '0;
    end else if (compress && (scan_so != exp_bit) && !(&mis_cnt)) begin
      mis_cnt <= mis_cnt + MIS_W'(1);
    end
  end
  assign mis_ok = (mis_cnt == '0);
`else
  assign mis_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      pat_cnt   <= '0;
      resp_done <= 1'b0;
      resp_pass <= 1'b0;
      resp_err  <= 1'b0;
    end else if (start) begin
      bit_cnt   <= '0;
      pat_cnt   <= '0;
      resp_done <= 1'b0;
      resp_pass <= 1'b0;
      resp_err  <= 1'b0;
    end else if (do_abort) begin
      resp_done <= 1'b1;
      resp_pass <= 1'b0;
      resp_err  <= 1'b1;
    end else begin
      if (new_win) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt_nx;
      end
      if (close_win) begin
        if (!(&pat_cnt)) pat_cnt <= pat_cnt + PAT_W'(1);
        if (bit_cnt_nx != ScanNum) resp_err <= 1'b1;
      end
      if (do_cmp) begin
        resp_done <= 1'b1;
        resp_pass <= (resp_sig == exp_sig) & ~resp_err & mis_ok;
      end
    end
  end

endmodule

// File: tb/tb_scan_resp_monitor.sv
// Randomized self-checking bench for scan_resp_monitor against a window-level model.
// Build with SCAN_RESP_BITCMP_EN to also cover the per-bit compare feature.
module tb_scan_resp_monitor;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lock = 1'b1;
  logic [19:0] scan_num = 20'd8;
  logic        se = 1'b0;
  logic        sdone = 1'b0;
  logic        so_vld = 1'b0;
  logic        scan_so = 1'b0;
  logic [31:0] exp_sig = '0;
  logic [31:0] resp_sig;
  logic [15:0] pat_cnt;
  logic        resp_done, resp_pass, resp_err;
`ifdef SCAN_RESP_BITCMP_EN
  logic        exp_bit = 1'b0;
  logic [15:0] mis_cnt;
`endif

  scan_resp_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ADPLL_LOCK (lock),
    .ScanNum    (scan_num),
    .test_se    (se),
    .scan_done  (sdone),
    .so_vld     (so_vld),
    .scan_so    (scan_so),
    .exp_sig    (exp_sig),
`ifdef SCAN_RESP_BITCMP_EN
    .exp_bit    (exp_bit),
    .mis_cnt    (mis_cnt),
`endif
    .resp_sig   (resp_sig),
    .pat_cnt    (pat_cnt),
    .resp_done  (resp_done),
    .resp_pass  (resp_pass),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Golden and driven bits per window; windows 1.. are the compressed ones.
  bit gold[3][64];
  bit drv[3][64];
  int len[3];

  function automatic logic [31:0] sig_of(input int upto, input bit use_gold);
    logic [31:0] m = SEED;
    for (int w = 1; w < upto; w++)
      for (int i = 0; i < len[w]; i++)
        m = (m << 1) ^ (m[31] ? POLY : 32'h0) ^ {31'h0, (use_gold ? gold[w][i] : drv[w][i])};
    return m;
  endfunction

  function automatic bit len_bad(input int upto);
    bit bad = 1'b0;
    for (int w = 0; w < upto; w++) if (len[w] != int'(scan_num)) bad = 1'b1;
    return bad;
  endfunction

  function automatic int mis_of(input int upto);
    int n = 0;
    for (int w = 1; w < upto; w++)
      for (int i = 0; i < len[w]; i++) if (drv[w][i] != gold[w][i]) n++;
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill(input int nflip);
    for (int w = 0; w < 3; w++) begin
      len[w] = 8;
      for (int i = 0; i < 64; i++) begin
        gold[w][i] = 1'($urandom_range(0, 1));
        drv[w][i]  = gold[w][i];
      end
    end
    if (nflip >= 1) begin
      int k = int'($urandom_range(0, 7));
      drv[2][k] = ~drv[2][k];
    end
    if (nflip >= 2) begin
      int k = int'($urandom_range(0, 7));
      drv[1][k] = ~drv[1][k];
    end
  endtask

  task automatic shift_window(input int w, input int nbits);
    se = 1'b1;
    tick(3);
    for (int i = 0; i < nbits; i++) begin
      so_vld  = 1'b1;
      scan_so = drv[w][i];
`ifdef SCAN_RESP_BITCMP_EN
      exp_bit = gold[w][i];
`endif
      tick(1);
      so_vld = 1'b0;
      tick(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic run_test(input string name, input int nwin, input bit merge_done);
    bit want_pass;
    exp_sig = sig_of(nwin, 1'b1);
    for (int w = 0; w < nwin; w++) begin
      shift_window(w, len[w]);
      if (merge_done && w == nwin - 1) begin
        se    = 1'b0;
        sdone = 1'b1;
        tick(6);
      end else begin
        se = 1'b0;
        tick(3);
        repeat (2) begin
          so_vld  = 1'b1;
          scan_so = 1'($urandom_range(0, 1));
          tick(1);
          so_vld = 1'b0;
          tick(1);
        end
        check({name, "_capt_sig"}, resp_sig, sig_of(w + 1, 1'b0));
        check({name, "_capt_pat"}, pat_cnt, w + 1);
        check({name, "_capt_err"}, resp_err, len_bad(w + 1));
      end
    end
    if (!merge_done) begin
      sdone = 1'b1;
      tick(5);
    end
    want_pass = (sig_of(nwin, 1'b0) == exp_sig) && !len_bad(nwin);
`ifdef SCAN_RESP_BITCMP_EN
    want_pass = want_pass && (mis_of(nwin) == 0);
    check({name, "_mis"}, mis_cnt, mis_of(nwin));
`endif
    check({name, "_done"}, resp_done, 1'b1);
    check({name, "_pat"}, pat_cnt, nwin);
    check({name, "_sig"}, resp_sig, sig_of(nwin, 1'b0));
    check({name, "_err"}, resp_err, len_bad(nwin));
    check({name, "_pass"}, resp_pass, want_pass);
    sdone = 1'b0;
    tick(3);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_sig"}, resp_sig, SEED);
    check({name, "_pat"}, pat_cnt, 0);
    check({name, "_done"}, resp_done, 1'b0);
    check({name, "_pass"}, resp_pass, 1'b0);
    check({name, "_err"}, resp_err, 1'b0);
`ifdef SCAN_RESP_BITCMP_EN
    check({name, "_mis"}, mis_cnt, 0);
`endif
  endtask

  initial begin
    tick(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick(2);

    fill(0);
    run_test("nominal", 3, 1'b0);
    check("nominal_pass_hi", resp_pass, 1'b1);

    fill(1);
    run_test("flip1", 3, 1'b0);

    fill(2);
    run_test("flip2", 3, 1'b0);

    fill(0);
    len[1] = 7;
    run_test("short", 3, 1'b0);

    // Abort during window 1, then recover and run a clean test.
    fill(0);
    shift_window(0, 8);
    se = 1'b0;
    tick(3);
    shift_window(1, 3);
    lock = 1'b0;
    tick(2);
    check("abort_done", resp_done, 1'b1);
    check("abort_err", resp_err, 1'b1);
    check("abort_pass", resp_pass, 1'b0);
    lock = 1'b1;
    tick(3);
    check("abort_hold_done", resp_done, 1'b1);
    se = 1'b0;
    tick(4);
    check("abort_idle_err", resp_err, 1'b1);
    fill(0);
    run_test("recover", 3, 1'b0);

    fill(0);
    run_test("merge", 3, 1'b1);

    // Reset asserted in the middle of a shift window.
    fill(0);
    exp_sig = sig_of(3, 1'b1);
    shift_window(0, 8);
    se = 1'b0;
    tick(3);
    shift_window(1, 4);
    rst_n = 1'b0;
    se    = 1'b0;
    tick(1);
    check_reset_vals("midrst");
    rst_n = 1'b1;
    tick(3);

    fill(0);
    run_test("post_rst", 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
